keypad_matrix_scanner: RTL



---
 rtl/keypad_matrix_scanner.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/keypad_matrix_scanner.sv
// Scans an active-low ROWS x COLS key matrix one column at a time. It debounces one key
// at a time and reports the key index with press and release strobes plus a held level.
module keypad_matrix_scanner #(
  parameter int ROWS     = 4,
  parameter int COLS     = 4,
  parameter int SCAN_DIV = 16,
  parameter int DEBOUNCE = 3,
  localparam int KW      = $clog2(ROWS*COLS)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [ROWS-1:0] row,
  output logic [COLS-1:0] col,
  output logic [KW-1:0]   key_code,
  output logic            key_valid,
  output logic            key_held,
  output logic            key_release
);

  localparam int RW   = $clog2(ROWS);
  localparam int CW   = $clog2(COLS);
  localparam int DIVW = $clog2(SCAN_DIV);
  localparam logic [3:0] DB = 4'(DEBOUNCE);

  typedef enum logic [2:0] {IDLE, SCAN, DEB_P, PRESSED, DEB_R} state_t;

  state_t            state_q;
  logic [ROWS-1:0]   rs1_q, rs_q;
  logic [DIVW-1:0]   div_q, div_d;
  logic [CW-1:0]     ci_q;
  logic [RW-1:0]     ri_q, low_idx_d;
  logic [3:0]        dcnt_q, dcnt_d;
  logic [COLS-1:0]   col_q;
  logic [KW-1:0]     key_code_q, code_hit_d, code_lat_d;
  logic              key_valid_q, key_held_q, key_release_q;
  logic              tick, any_low, rs_ri;

  assign tick    = (div_q == DIVW'(SCAN_DIV-1));
  assign div_d   = tick ? '0 : div_q + DIVW'(1);
  assign any_low = ~&rs_q;
  assign rs_ri   = rs_q[ri_q];
  assign dcnt_d  = dcnt_q + 4'd1;

  // Lowest row index wins when several rows of the driven column are low.
  always_comb begin
    low_idx_d = '0;
    for (int i = ROWS-1; i >= 0; i--) begin
      if (!rs_q[i]) low_idx_d = RW'(i);
    end
  end

  assign code_hit_d = KW'(ci_q) * KW'(ROWS) + KW'(low_idx_d);
  assign code_lat_d = KW'(ci_q) * KW'(ROWS) + KW'(ri_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rs1_q <= '1;
      rs_q  <= '1;
      div_q <= '0;
    end else begin
      rs1_q <= row;
      rs_q  <= rs1_q;
      div_q <= div_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      ci_q          <= '0;
      ri_q          <= '0;
      dcnt_q        <= '0;
      col_q         <= '0;
      key_code_q    <= '0;
      key_valid_q   <= 1'b0;
      key_held_q    <= 1'b0;
      key_release_q <= 1'b0;
    end else begin
      key_valid_q   <= 1'b0;
      key_release_q <= 1'b0;
      if (tick) begin
        unique case (state_q)
          IDLE: begin
            col_q <= '0;
            if (any_low) begin
              state_q <= SCAN;
              ci_q    <= '0;
              col_q   <= ~COLS'(1);
            end
          end
          SCAN: begin
            if (any_low) begin
              ri_q <= low_idx_d;
              if (DEBOUNCE == 1) begin
                state_q     <= PRESSED;
                key_code_q  <= code_hit_d;
                key_valid_q <= 1'b1;
                key_held_q  <= 1'b1;
              end else begin
                state_q <= DEB_P;
                dcnt_q  <= 4'd1;
              end
            end else if (ci_q == CW'(COLS-1)) begin
              state_q <= IDLE;
              col_q   <= '0;
            end else begin
              ci_q  <= ci_q + CW'(1);
              col_q <= ~(COLS'(1) << (ci_q + CW'(1)));
            end
          end
          DEB_P: begin
            if (!rs_ri) begin
              if (dcnt_d == DB) begin
                state_q     <= PRESSED;
                dcnt_q      <= '0;
                key_code_q  <= code_lat_d;
                key_valid_q <= 1'b1;
                key_held_q  <= 1'b1;
              end else begin
                dcnt_q <= dcnt_d;
              end
            end else begin
              state_q <= IDLE;
              dcnt_q  <= '0;
              col_q   <= '0;
            end
          end
          PRESSED: begin
            if (rs_ri) begin
              if (DEBOUNCE == 1) begin
                state_q       <= IDLE;
                col_q         <= '0;
                key_held_q    <= 1'b0;
                key_release_q <= 1'b1;
              end else begin
                state_q <= DEB_R;
                dcnt_q  <= 4'd1;
              end
            end
          end
          DEB_R: begin
            if (rs_ri) begin
              if (dcnt_d == DB) begin
                state_q       <= IDLE;
                dcnt_q        <= '0;
                col_q         <= '0;
                key_held_q    <= 1'b0;
                key_release_q <= 1'b1;
              end else begin
                dcnt_q <= dcnt_d;
              end
            end else begin
              state_q <= PRESSED;
              dcnt_q  <= '0;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign col         = col_q;
  assign key_code    = key_code_q;
  assign key_valid   = key_valid_q;
  assign key_held    = key_held_q;
  assign key_release = key_release_q;

endmodule
